cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 70 +++++++
 tb/tb_cpu_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: two-byte fetch / decode / execute / write-back sequencer for a tiny CPU.
// Define TINY_CPU_SINGLE_STEP_EN to add step_in for single-instruction stepping from IDLE.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_in,
`ifdef TINY_CPU_SINGLE_STEP_EN
  input  logic        step_in,
`endif
  output logic        mem_req_out,
  output logic [8:0]  mem_addr_out,
  input  logic        mem_ack_in,
  input  logic [7:0]  mem_rdata_in,
  output logic [15:0] inst_out,
  input  logic [1:0]  inst_type_in,
  input  logic        cond_en_in,
  input  logic [7:0]  imm_in,
  input  logic        flag_z_in,
  output logic        reg_we_out,
  output logic [7:0]  pc_out,
  output logic        halted_out
);
  typedef enum logic [2:0] {IDLE, FETCH_HI, FETCH_LO, DECODE, EXEC, WB} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_pc;
  logic [15:0] r_inst;
  logic        r_skip;
  logic        w_go, w_jump, w_wb, w_end;
`ifdef TINY_CPU_SINGLE_STEP_EN
  assign w_go = run_in | step_in;
`else
  assign w_go = run_in;
`endif
  assign w_jump = inst_type_in == 2'b11 && !r_skip;
  assign w_wb   = !inst_type_in[1] && !r_skip;
  // A stepped instruction returns to IDLE because run_in is low when it ends.
  assign w_end  = run_in;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_go ? FETCH_HI : IDLE;
      FETCH_HI: w_next = mem_ack_in ? FETCH_LO : FETCH_HI;
      FETCH_LO: w_next = mem_ack_in ? DECODE : FETCH_LO;
      DECODE:   w_next = EXEC;
      EXEC:     w_next = w_wb ? WB : (w_end ? FETCH_HI : IDLE);
      WB:       w_next = w_end ? FETCH_HI : IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= 8'h00;
      r_inst  <= 16'h0000;
      r_skip  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH_HI && mem_ack_in) r_inst[15:8] <= mem_rdata_in;
      if (r_state == FETCH_LO && mem_ack_in) r_inst[7:0] <= mem_rdata_in;
      if (r_state == DECODE) r_skip <= cond_en_in & ~flag_z_in;
      if (r_state == EXEC) r_pc <= w_jump ? imm_in : r_pc + 8'd1;
    end
  end
  assign mem_req_out  = r_state == FETCH_HI || r_state == FETCH_LO;
  assign mem_addr_out = {r_pc, r_state == FETCH_LO};
  assign inst_out     = r_inst;
  assign reg_we_out   = r_state == WB;
  assign pc_out       = r_pc;
  assign halted_out   = r_state == IDLE;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench; a reference model predicts per-instruction pc, word, write-back and latency.
module tb_cpu_sequencer;
  logic        clk, rst_n, run_in, step_in;
  logic        mem_req_out, mem_ack_in, cond_en_in, flag_z_in, reg_we_out, halted_out;
  logic [8:0]  mem_addr_out;
  logic [7:0]  mem_rdata_in, imm_in, pc_out;
  logic [15:0] inst_out;
  logic [1:0]  inst_type_in;
  logic [7:0]  mem [512];
  int          wait_n, wcnt;
  int          n_tot = 0, n_bad = 0, cyc = 0, starts = 0;

  typedef struct {logic [7:0] pc; logic [15:0] inst; int we; int lat;} exp_t;
  exp_t q[$];
  logic [7:0] mpc;

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run_in(run_in),
`ifdef TINY_CPU_SINGLE_STEP_EN
    .step_in(step_in),
`endif
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out), .mem_ack_in(mem_ack_in),
    .mem_rdata_in(mem_rdata_in), .inst_out(inst_out), .inst_type_in(inst_type_in),
    .cond_en_in(cond_en_in), .imm_in(imm_in), .flag_z_in(flag_z_in),
    .reg_we_out(reg_we_out), .pc_out(pc_out), .halted_out(halted_out)
  );

  assign inst_type_in = inst_out[15:14];
  assign cond_en_in   = inst_out[13];
  assign imm_in       = inst_out[7:0];
  assign mem_ack_in   = mem_req_out && wcnt == wait_n;
  assign mem_rdata_in = mem[mem_addr_out];

  initial clk = 0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) wcnt <= (mem_req_out && !mem_ack_in) ? wcnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] pc, input logic [15:0] inst);
    mem[{pc, 1'b0}] = inst[15:8];
    mem[{pc, 1'b1}] = inst[7:0];
  endtask

  task automatic model(input int n, input logic z, input int w);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      logic [15:0] ins;
      logic skip;
      ins  = {mem[{mpc, 1'b0}], mem[{mpc, 1'b1}]};
      skip = ins[13] & ~z;
      e.pc = mpc; e.inst = ins;
      e.we = (ins[15:14] < 2'd2 && !skip) ? 1 : 0;
      e.lat = 4 + e.we + 2 * w;
      q.push_back(e);
      mpc = (ins[15:14] == 2'b11 && !skip) ? ins[7:0] : mpc + 8'd1;
    end
  endtask

  // Instruction monitor: an instruction spans from its first FETCH_HI cycle to the next start or IDLE.
  logic       open = 0, prev_hi = 0;
  logic [7:0] cur_pc;
  logic [8:0] held_addr;
  int         cur_we, t0;
  task automatic finish_inst();
    exp_t e;
    chk("inst_expected", q.size() > 0, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc_start", cur_pc, e.pc);
      chk("inst_word", inst_out, e.inst);
      chk("we_count", cur_we, e.we);
      chk("latency", cyc - t0, e.lat);
    end
  endtask
  initial forever begin
    logic w_hi;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      open = 0; prev_hi = 0;
    end else begin
      w_hi = mem_req_out && !mem_addr_out[0];
      if (w_hi && !prev_hi) begin
        if (open) finish_inst();
        open = 1; cur_pc = mem_addr_out[8:1]; cur_we = 0; t0 = cyc; starts++;
      end else if (halted_out && open) begin
        finish_inst();
        open = 0;
      end
      if (reg_we_out) cur_we++;
      if (mem_req_out && wcnt == 0) held_addr = mem_addr_out;
      else if (mem_req_out) chk("addr_hold", mem_addr_out, held_addr);
      prev_hi = w_hi;
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (!(halted_out && !open) && k < 300) begin @(negedge clk); #1; k++; end
    chk("halted", halted_out, 1);
  endtask

  task automatic run_n(input int n, input logic z, input int w, input int dly);
    int k = 0, tgt;
    flag_z_in = z; wait_n = w;
    model(n, z, w);
    tgt = starts + n;
    run_in = 1;
    while (starts < tgt && k < 300) begin @(negedge clk); #1; k++; end
    chk("starts", starts, tgt);
    repeat (dly) @(negedge clk);
    run_in = 0;
    wait_idle();
    chk("pc_end", pc_out, mpc);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    put(8'h00, 16'h2045);
    put(8'h01, 16'h0000);
    put(8'h02, 16'h4000);
    put(8'h03, 16'hC07F);
    put(8'h7F, 16'h2001);
    put(8'h80, 16'h2001);
    put(8'h81, 16'h0000);
    put(8'h82, 16'h8000);
    put(8'h83, 16'hC0FF);
    put(8'hFF, 16'h8000);
    rst_n = 0; run_in = 0; step_in = 0; flag_z_in = 0; wait_n = 0; mpc = 8'h00;
    #3;
    chk("rst_halted", halted_out, 1);
    chk("rst_pc", pc_out, 8'h00);
    chk("rst_inst", inst_out, 16'h0000);
    chk("rst_req", mem_req_out, 0);
    chk("rst_addr", mem_addr_out, 9'h000);
    chk("rst_we", reg_we_out, 0);
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_stays", halted_out, 1);
    run_n(1, 1'b1, 0, 0);
    chk("inst_2045", inst_out, 16'h2045);
    run_n(2, 1'b1, 0, 0);
    run_n(1, 1'b0, 0, 0);
    chk("jump_pc", pc_out, 8'h7F);
    run_n(1, 1'b0, 0, 0);
    run_n(1, 1'b1, 0, 0);
    run_n(1, 1'b1, 3, 0);
    run_n(2, 1'b0, 0, 0);
    run_n(1, 1'b0, 0, 1);
    chk("wrap_pc", pc_out, 8'h00);
    run_n(1, 1'b0, 0, 0);
    begin
      int k = 0;
      wait_n = 6; run_in = 1;
      while (!(mem_req_out && mem_addr_out[0]) && k < 100) begin @(negedge clk); k++; end
      chk("reached_lo", mem_req_out && mem_addr_out[0], 1);
      #2 rst_n = 0; run_in = 0;
      #1;
      chk("arst_req", mem_req_out, 0);
      chk("arst_pc", pc_out, 8'h00);
      chk("arst_inst", inst_out, 16'h0000);
      chk("arst_halted", halted_out, 1);
      q.delete();
      @(negedge clk); rst_n = 1; wait_n = 0;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", halted_out, 1);
      chk("post_rst_req", mem_req_out, 0);
    end
`ifdef TINY_CPU_SINGLE_STEP_EN
    begin
      int tgt;
      mpc = 8'h00; flag_z_in = 1;
      model(1, 1'b1, 0);
      tgt = starts + 1;
      step_in = 1;
      @(negedge clk); step_in = 0;
      wait_idle();
      repeat (5) @(negedge clk);
      chk("step_starts", starts, tgt);
      chk("step_pc", pc_out, 8'h01);
      chk("step_idle", halted_out, 1);
      chk("step_queue", q.size(), 0);
    end
`endif
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
